os_matmul_sequencer: RTL
========================

OS_MATMUL_SEQUENCER -- requirements
Module: os_matmul_sequencer

Interface
REQ-001 Parameters SHALL be, one per line:
- WORD_SIZE, 16, operand/result word width.
- ROWS, 4, array rows.
- COLS, 4, array columns.
- K_DEPTH, 4, inner dimension (must be ≥1).
REQ-002 Ports SHALL be, one per line:
- clk  in  1  sole clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  request run, sampled at rising edge.
- abort  in  1  synchronous cancel of a run in progress.
- left_matrix  in  ROWS*K_DEPTH*WORD_SIZE  A[r][k] at word r*K_DEPTH+k.
- top_matrix  in  K_DEPTH*COLS*WORD_SIZE  B[k][c] at word k*COLS+c.
- bottom_out  in  COLS*WORD_SIZE  array bottom outputs.
- curr_cycle_left_in  out  ROWS*WORD_SIZE  skewed left lanes.
- curr_cycle_top_in  out  COLS*WORD_SIZE  skewed top lanes.
- sys_rst  out  1  array accumulator clear.
- set_stationary, stat_bit_in  out  1 each  PE control.
- fsm_out_select_in  out  1  PE accumulator-to-output select.
- matmul_output  out  COLS*WORD_SIZE  equals bottom_out.
- output_col_valid  out  COLS  per-column valid.
- output_row_idx  out  $clog2(ROWS)+1  row index of the current valid output.
- busy  out  1  run in progress.
- done  out  1  one-cycle completion pulse.

Function
REQ-003 All outputs except matmul_output SHALL be registered on the rising edge of clk.
REQ-004 Define F = K_DEPTH+max(ROWS,COLS)-1 and W = ROWS+COLS-1.
REQ-005 States SHALL be IDLE, CLEAR, FEED, PROPAGATE, SELECT, OUTPUT, DONE.
REQ-006 IDLE behaviour:
- sys_rst=1, busy=0, lanes=0.
- start=1 SHALL go to CLEAR and set busy=1.
REQ-007 CLEAR SHALL last 1 cycle with sys_rst=1, then go to FEED with sys_rst=0.
REQ-008 FEED SHALL last F cycles, t=0..F-1:
- left lane r = A[r][t-r] if 0≤t-r<K_DEPTH, else 0.
- top lane c = B[t-c][c] if 0≤t-c<K_DEPTH, else 0.
REQ-009 PROPAGATE SHALL last W cycles with all lanes 0.
REQ-010 SELECT SHALL last 1 cycle with fsm_out_select_in=1.
REQ-011 OUTPUT SHALL last ROWS cycles:
- fsm_out_select_in=0, output_col_valid all ones.
- output_row_idx = ROWS-1 on the first cycle, decrementing to 0.
REQ-012 DONE SHALL last 1 cycle with done=1, busy=0, output_col_valid=0, then go to IDLE.
REQ-013 start-accepting edge to done high SHALL be exactly F+W+ROWS+2 cycles.
REQ-014 start while busy=1 SHALL be ignored; start in DONE SHALL be ignored.
REQ-015 abort=1 in any non-IDLE state SHALL, at the next edge:
- go to IDLE, zero lanes and output_col_valid, assert sys_rst.
- leave done=0.
REQ-016 abort=1 together with start=1 in IDLE SHALL give abort priority: stay IDLE.
REQ-017 set_stationary and stat_bit_in SHALL be 0 in every state.
REQ-018 output_col_valid SHALL be 0 outside OUTPUT.
REQ-019 The source SHALL hold left_matrix and top_matrix stable while busy=1; the block SHALL not capture them.
REQ-020 Phase counters SHALL be sized to hold max(F, W, ROWS) without wrap.

Reset
REQ-021 rst=0 SHALL asynchronously force the following, held until the first edge after rst=1:
- state=IDLE, sys_rst=1, busy=0, done=0.
- lanes=0, fsm_out_select_in=0, output_col_valid=0, output_row_idx=0, counters=0.
- run_cycles=0 when present.
REQ-022 Reset mid-run SHALL discard the run with no done pulse.

Configuration
REQ-023 Macro OS_PERF_CNT_EN:
- Defined: adds output run_cycles [31:0]; cleared on start acceptance; increments each cycle busy=1; saturates at all-ones; holds after done.
- Undefined: port and logic absent; all other behaviour identical.

Verification
REQ-024 Directed scenarios:
- 2x2, K_DEPTH=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> done 10 cycles after start; rows [43,50] (row_idx 1) then [19,22] (row_idx 0).
- 4x4, K_DEPTH=4, A=identity, B=values 1..16 -> done at cycle 20; outputs equal B row-wise, bottom row first.
- Pulse start at FEED t=1 -> ignored; done timing unchanged.
- abort at PROPAGATE cycle 2 -> IDLE next cycle, sys_rst=1, no done; a new start completes correctly.
- rst low during OUTPUT -> all outputs at reset values immediately (asynchronous), no done.
- With OS_PERF_CNT_EN, 2x2 K_DEPTH=2 run -> run_cycles=10 at done.

Source files
------------

// File: rtl/os_matmul_sequencer.sv
// Control sequencer for an output-stationary systolic matmul array: clears, feeds skewed operands, drains results.
// Optional OS_PERF_CNT_EN adds a saturating run_cycles counter port.
module os_matmul_sequencer #(
    parameter int WORD_SIZE = 16,
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int K_DEPTH   = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                abort,
    input  logic [ROWS*K_DEPTH*WORD_SIZE-1:0]   left_matrix,
    input  logic [K_DEPTH*COLS*WORD_SIZE-1:0]   top_matrix,
    input  logic [COLS*WORD_SIZE-1:0]           bottom_out,
    output logic [ROWS*WORD_SIZE-1:0]           curr_cycle_left_in,
    output logic [COLS*WORD_SIZE-1:0]           curr_cycle_top_in,
    output logic                                sys_rst,
    output logic                                set_stationary,
    output logic                                stat_bit_in,
    output logic                                fsm_out_select_in,
    output logic [COLS*WORD_SIZE-1:0]           matmul_output,
    output logic [COLS-1:0]                     output_col_valid,
    output logic [$clog2(ROWS):0]               output_row_idx,
`ifdef OS_PERF_CNT_EN
    output logic [31:0]                         run_cycles,
`endif
    output logic                                busy,
    output logic                                done
);
    localparam int MAX_RC = (ROWS > COLS) ? ROWS : COLS;
    localparam int F      = K_DEPTH + MAX_RC - 1;
    localparam int W      = ROWS + COLS - 1;
    localparam int MAX_FW = (F > W) ? F : W;
    localparam int MAXC   = (MAX_FW > ROWS) ? MAX_FW : ROWS;
    localparam int CW     = $clog2(MAXC + 1);
    localparam int RIW    = $clog2(ROWS) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FEED, S_PROP, S_SELECT, S_OUTPUT, S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [ROWS*WORD_SIZE-1:0] left_q, left_d;
    logic [COLS*WORD_SIZE-1:0] top_q, top_d;
    logic                      sys_rst_q, sys_rst_d;
    logic                      sel_q, sel_d;
    logic [COLS-1:0]           valid_q, valid_d;
    logic [RIW-1:0]            row_idx_q, row_idx_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      accept;

    assign accept = (state_q == S_IDLE) && start && !abort;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:   if (accept) begin state_d = S_CLEAR; cnt_d = '0; end
            S_CLEAR:  begin state_d = S_FEED; cnt_d = '0; end
            S_FEED:   if (cnt_q == CW'(F - 1)) begin state_d = S_PROP; cnt_d = '0; end
                      else cnt_d = cnt_q + 1'b1;
            S_PROP:   if (cnt_q == CW'(W - 1)) begin state_d = S_SELECT; cnt_d = '0; end
                      else cnt_d = cnt_q + 1'b1;
            S_SELECT: begin state_d = S_OUTPUT; cnt_d = '0; end
            S_OUTPUT: if (cnt_q == CW'(ROWS - 1)) begin state_d = S_DONE; cnt_d = '0; end
                      else cnt_d = cnt_q + 1'b1;
            S_DONE:   begin state_d = S_IDLE; cnt_d = '0; end
            default:  begin state_d = S_IDLE; cnt_d = '0; end
        endcase
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    // Outputs are decoded from the next state so every registered output lines up with its state.
    always_comb begin
        int k;
        left_d    = '0;
        top_d     = '0;
        k         = 0;
        sys_rst_d = (state_d == S_IDLE) || (state_d == S_CLEAR);
        busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d    = (state_d == S_DONE);
        sel_d     = (state_d == S_SELECT);
        valid_d   = (state_d == S_OUTPUT) ? '1 : '0;
        row_idx_d = (state_d == S_OUTPUT) ? (RIW'(ROWS - 1) - RIW'(cnt_d)) : '0;
        if (state_d == S_FEED) begin
            for (int r = 0; r < ROWS; r++) begin
                k = int'(cnt_d) - r;
                if (k >= 0 && k < K_DEPTH)
                    left_d[r*WORD_SIZE +: WORD_SIZE] = left_matrix[(r*K_DEPTH + k)*WORD_SIZE +: WORD_SIZE];
            end
            for (int c = 0; c < COLS; c++) begin
                k = int'(cnt_d) - c;
                if (k >= 0 && k < K_DEPTH)
                    top_d[c*WORD_SIZE +: WORD_SIZE] = top_matrix[(k*COLS + c)*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            left_q    <= '0;
            top_q     <= '0;
            sys_rst_q <= 1'b1;
            sel_q     <= 1'b0;
            valid_q   <= '0;
            row_idx_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            left_q    <= left_d;
            top_q     <= top_d;
            sys_rst_q <= sys_rst_d;
            sel_q     <= sel_d;
            valid_q   <= valid_d;
            row_idx_q <= row_idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

`ifdef OS_PERF_CNT_EN
    logic [31:0] run_cycles_q, run_cycles_d;

    always_comb begin
        run_cycles_d = run_cycles_q;
        if (accept)
            run_cycles_d = '0;
        else if (busy_q && run_cycles_q != '1)
            run_cycles_d = run_cycles_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) run_cycles_q <= '0;
        else      run_cycles_q <= run_cycles_d;
    end

    assign run_cycles = run_cycles_q;
`endif

    assign curr_cycle_left_in = left_q;
    assign curr_cycle_top_in  = top_q;
    assign sys_rst            = sys_rst_q;
    assign set_stationary     = 1'b0;
    assign stat_bit_in        = 1'b0;
    assign fsm_out_select_in  = sel_q;
    assign matmul_output      = bottom_out;
    assign output_col_valid   = valid_q;
    assign output_row_idx     = row_idx_q;
    assign busy               = busy_q;
    assign done               = done_q;
endmodule
